fetch_pc_ctrl: RTL and testbench

- Owns the F-stage program-counter register and sequences it every cycle.
- Selects between four sources: reset vector, exception-handler vector on a CP0 request, hold on a hazard stall, or the NPC-computed next PC.
- Tracks the branch-delay-slot flag and flags fetch address exceptions (AdEL) for the F-stage instruction.
- Keeps saturating fetch and stall performance counters for the CP0/debug path.

---
 rtl/fetch_pc_ctrl_pkg.sv | 18 +
 rtl/fetch_addr_check.sv | 22 ++
 rtl/fetch_sat_counter.sv | 23 ++
 rtl/fetch_pc_ctrl.sv | 95 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encodings, exception codes and the
// address-map defaults used by fetch, CP0 and the instruction memory.
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_VEC  = 2'd2
  } fetch_state_e;

  localparam logic [4:0]  EXC_ADEL       = 5'd4;
  localparam logic [4:0]  EXC_NONE       = 5'd0;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LAST    = 32'h0000_6FFC;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-address legality check against an inclusive window.
// Shared by the F-stage fetch path and the M-stage data address check.
module fetch_addr_check
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = DEF_RESET_PC,
  parameter logic [31:0] ADDR_HI = DEF_IM_LAST
) (
  input  logic [31:0] i_addr,
  output logic        o_exc_valid,
  output logic [4:0]  o_exc_code
);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (i_addr[1:0] != 2'b00);
  assign w_out_of_range = (i_addr < ADDR_LO) || (i_addr > ADDR_HI);
  assign o_exc_valid    = w_misaligned || w_out_of_range;
  assign o_exc_code     = o_exc_valid ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/fetch_sat_counter.sv
// Unsigned event counter with synchronous clear; sticks at all-ones.
module fetch_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC sequencer: reset > CP0 request > hazard stall > NPC advance,
// with delay-slot tracking, fetch AdEL detection and perf counters.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] IM_LAST    = DEF_IM_LAST,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             req,
  input  logic [31:0]      F_nextPC,
  input  logic             D_isJump,
  output logic [31:0]      F_PC,
  output logic             F_BD,
  output logic             F_ExcValid,
  output logic [4:0]       F_ExcCode,
  output logic             F_forceNop,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_bd, w_bd_nxt;
  logic         w_fetch_inc;
  logic         w_stall_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_bd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_bd    <= w_bd_nxt;
    end
  end

  // The current state never gates the transition: VEC is left (or re-entered)
  // by the same req/stall priority as any other state.
  always_comb begin
    w_state_nxt = ST_RUN;
    w_pc_nxt    = F_nextPC;
    w_bd_nxt    = D_isJump;
    w_fetch_inc = 1'b0;
    w_stall_inc = 1'b0;
    if (req) begin
      w_state_nxt = ST_VEC;
      w_pc_nxt    = HANDLER_PC;
      w_bd_nxt    = 1'b0;
    end else if (stall) begin
      w_state_nxt = ST_HOLD;
      w_pc_nxt    = r_pc;
      w_bd_nxt    = r_bd;
      w_stall_inc = 1'b1;
    end else begin
      w_fetch_inc = 1'b1;
    end
  end

  fetch_addr_check #(
    .ADDR_LO (RESET_PC),
    .ADDR_HI (IM_LAST)
  ) u_addr_check (
    .i_addr      (r_pc),
    .o_exc_valid (F_ExcValid),
    .o_exc_code  (F_ExcCode)
  );

  fetch_sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk     (clk),
    .i_clr   (reset),
    .i_inc   (w_fetch_inc),
    .o_count (fetch_cnt)
  );

  fetch_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clr   (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  assign F_PC       = r_pc;
  assign F_BD       = r_bd;
  assign F_forceNop = F_ExcValid;
  assign state      = r_state;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with 4-bit counters to reach saturation.
module tb_fetch_pc_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             req;
  logic [31:0]      F_nextPC;
  logic             D_isJump;
  logic [31:0]      F_PC;
  logic             F_BD;
  logic             F_ExcValid;
  logic [4:0]       F_ExcCode;
  logic             F_forceNop;
  logic [1:0]       state;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_pc_ctrl #(
    .RESET_PC   (32'h0000_3000),
    .HANDLER_PC (32'h0000_4180),
    .IM_LAST    (32'h0000_6FFC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req        (req),
    .F_nextPC   (F_nextPC),
    .D_isJump   (D_isJump),
    .F_PC       (F_PC),
    .F_BD       (F_BD),
    .F_ExcValid (F_ExcValid),
    .F_ExcCode  (F_ExcCode),
    .F_forceNop (F_forceNop),
    .state      (state),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc, input logic [1:0] st,
                        input logic bd, input logic [3:0] fc, input logic [3:0] sc);
    chk({tag, ".pc"},    F_PC,      pc);
    chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
    chk({tag, ".bd"},    {31'd0, F_BD}, {31'd0, bd});
    chk({tag, ".fcnt"},  {28'd0, fetch_cnt}, {28'd0, fc});
    chk({tag, ".scnt"},  {28'd0, stall_cnt}, {28'd0, sc});
  endtask

  task automatic chk_exc(input string tag, input logic v);
    chk({tag, ".excv"}, {31'd0, F_ExcValid}, {31'd0, v});
    chk({tag, ".code"}, {27'd0, F_ExcCode},  v ? 32'd4 : 32'd0);
    chk({tag, ".nop"},  {31'd0, F_forceNop}, {31'd0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; req = 1'b0; F_nextPC = 32'h0; D_isJump = 1'b0;
    step(); step();
    chk_pc("rst", 32'h3000, 2'd0, 1'b0, 4'd0, 4'd0);
    chk_exc("rst", 1'b0);

    // Sequential advance
    reset = 1'b0; F_nextPC = 32'h3004;
    step(); chk_pc("seq1", 32'h3004, 2'd0, 1'b0, 4'd1, 4'd0);
    F_nextPC = 32'h3008;
    step(); chk_pc("seq2", 32'h3008, 2'd0, 1'b0, 4'd2, 4'd0);

    // Three stalled cycles at 0x3008
    stall = 1'b1; F_nextPC = 32'h300C;
    step(); chk_pc("stl1", 32'h3008, 2'd1, 1'b0, 4'd2, 4'd1);
    step(); chk_pc("stl2", 32'h3008, 2'd1, 1'b0, 4'd2, 4'd2);
    step(); chk_pc("stl3", 32'h3008, 2'd1, 1'b0, 4'd2, 4'd3);
    stall = 1'b0;
    step(); chk_pc("stlrel", 32'h300C, 2'd0, 1'b0, 4'd3, 4'd3);

    // Jump sets delay-slot flag for exactly one fetch
    D_isJump = 1'b1; F_nextPC = 32'h3010;
    step(); chk_pc("jmp", 32'h3010, 2'd0, 1'b1, 4'd4, 4'd3);
    D_isJump = 1'b0; F_nextPC = 32'h3020;
    step(); chk_pc("jmpds", 32'h3020, 2'd0, 1'b0, 4'd5, 4'd3);

    // req beats stall and suppresses BD; held req stays in VEC
    req = 1'b1; stall = 1'b1; D_isJump = 1'b1; F_nextPC = 32'h3024;
    step(); chk_pc("reqstl", 32'h4180, 2'd2, 1'b0, 4'd5, 4'd3);
    stall = 1'b0;
    step(); chk_pc("reqhold", 32'h4180, 2'd2, 1'b0, 4'd5, 4'd3);
    req = 1'b0; D_isJump = 1'b0; F_nextPC = 32'h4184;
    step(); chk_pc("vecexit", 32'h4184, 2'd0, 1'b0, 4'd6, 4'd3);

    // Fetch address exceptions
    F_nextPC = 32'h3002;
    step(); chk("mis.pc", F_PC, 32'h3002); chk_exc("mis", 1'b1);
    F_nextPC = 32'h7000;
    step(); chk("hi.pc", F_PC, 32'h7000); chk_exc("hi", 1'b1);
    F_nextPC = 32'h6FFC;
    step(); chk("last.pc", F_PC, 32'h6FFC); chk_exc("last", 1'b0);
    F_nextPC = 32'h2FFC;
    step(); chk("lo.pc", F_PC, 32'h2FFC); chk_exc("lo", 1'b1);
    F_nextPC = 32'h3000;
    step(); chk_pc("first", 32'h3000, 2'd0, 1'b0, 4'd11, 4'd3); chk_exc("first", 1'b0);

    // fetch_cnt saturation
    for (int i = 1; i <= 20; i++) begin
      F_nextPC = 32'h3000 + 32'(4 * i);
      step();
    end
    chk_pc("fsat", 32'h3050, 2'd0, 1'b0, 4'd15, 4'd3);

    // Reset mid-stall clears everything
    stall = 1'b1;
    step(); chk_pc("prerst", 32'h3050, 2'd1, 1'b0, 4'd15, 4'd4);
    reset = 1'b1;
    step(); chk_pc("rststl", 32'h3000, 2'd0, 1'b0, 4'd0, 4'd0);
    req = 1'b1;
    step(); chk_pc("rstreq", 32'h3000, 2'd0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0; req = 1'b0;

    // stall_cnt saturation
    for (int i = 0; i < 18; i++) step();
    chk_pc("ssat", 32'h3000, 2'd1, 1'b0, 4'd0, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
